// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the serial packet framer/deframer pair.
// Flag/escape bytes, CRC-16/PPP parameters and the receive FSM state type.
package uart_frame_pkg;

   localparam logic [7:0]  FLAG     = 8'h7E;
   localparam logic [7:0]  ESC      = 8'h7D;
   localparam logic [7:0]  ESC_XOR  = 8'h20;

   localparam logic [15:0] FCS_INIT = 16'hFFFF;
   localparam logic [15:0] FCS_GOOD = 16'hF0B8;
   localparam logic [15:0] FCS_POLY = 16'h8408;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      IDLE  = 2'd1,
      DATA  = 2'd2,
      ESC_S = 2'd3
   } rx_state_e;

endpackage

// File: rtl/crc16_ppp_byte.sv
// Combinational one-byte update of the reflected CRC-16/PPP register.
// Shared by the receive deframer and the transmit framer.
module crc16_ppp_byte
   import uart_frame_pkg::*;
(
   input  logic [15:0] fcs_in,
   input  logic [7:0]  data_in,
   output logic [15:0] fcs_next_c
);

   logic [15:0] crc_c;

   // LSB-first shift, eight bits per byte
   always_comb begin
      crc_c = fcs_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         if (crc_c[0]) begin
            crc_c = (crc_c >> 1) ^ FCS_POLY;
         end else begin
            crc_c = crc_c >> 1;
         end
      end
   end

   assign fcs_next_c = crc_c;

endmodule

// File: rtl/uart_rx_deframer.sv
// Flag-delimited frame decoder: removes byte stuffing, holds back the trailing
// two bytes as FCS, checks CRC-16/PPP and reports one status pulse per frame.
module uart_rx_deframer
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN  = 256,
   parameter int unsigned LEN_BITS = $clog2(MAX_LEN + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          in_data,
   input  logic                in_strobe,
   output logic [7:0]          out_data,
   output logic                out_strobe,
   output logic                frame_done,
   output logic                frame_good,
   output logic [LEN_BITS-1:0] frame_len
);

   localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(MAX_LEN);

   rx_state_e           state_q,      state_d;
   logic [15:0]         fcs_q,        fcs_d;
   logic [7:0]          dly0_q,       dly0_d;
   logic [7:0]          dly1_q,       dly1_d;
   logic [1:0]          cnt_q,        cnt_d;
   logic [LEN_BITS-1:0] len_q,        len_d;
   logic [7:0]          out_data_q,   out_data_d;
   logic                out_strobe_q, out_strobe_d;
   logic                frame_done_q, frame_done_d;
   logic                frame_good_q, frame_good_d;
   logic [LEN_BITS-1:0] frame_len_q,  frame_len_d;

   logic [7:0]          byte_c;
   logic [15:0]         fcs_next_c;
   logic                proc_c;

   // Escaped bytes are restored before they reach the CRC and delay line
   assign byte_c = (state_q == ESC_S) ? (in_data ^ ESC_XOR) : in_data;

   crc16_ppp_byte u_crc (
      .fcs_in     (fcs_q),
      .data_in    (byte_c),
      .fcs_next_c (fcs_next_c)
   );

   always_comb begin
      state_d      = state_q;
      fcs_d        = fcs_q;
      dly0_d       = dly0_q;
      dly1_d       = dly1_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      out_data_d   = out_data_q;
      out_strobe_d = 1'b0;
      frame_done_d = 1'b0;
      frame_good_d = frame_good_q;
      frame_len_d  = frame_len_q;
      proc_c       = 1'b0;

      if (in_strobe) begin
         case (state_q)
            HUNT: begin
               if (in_data == FLAG) begin
                  state_d = IDLE;
                  fcs_d   = FCS_INIT;
                  cnt_d   = 2'd0;
                  len_d   = '0;
               end
            end
            IDLE: begin
               if (in_data == ESC) begin
                  state_d = ESC_S;
               end else if (in_data != FLAG) begin
                  state_d = DATA;
                  proc_c  = 1'b1;
               end
            end
            DATA: begin
               if (in_data == FLAG) begin
                  frame_done_d = 1'b1;
                  frame_good_d = (cnt_q == 2'd2) && (fcs_q == FCS_GOOD);
                  frame_len_d  = len_q;
                  state_d      = IDLE;
                  fcs_d        = FCS_INIT;
                  cnt_d        = 2'd0;
                  len_d        = '0;
               end else if (in_data == ESC) begin
                  state_d = ESC_S;
               end else begin
                  proc_c = 1'b1;
               end
            end
            ESC_S: begin
               if (in_data == FLAG) begin
                  frame_done_d = 1'b1;
                  frame_good_d = 1'b0;
                  frame_len_d  = len_q;
                  state_d      = IDLE;
                  fcs_d        = FCS_INIT;
                  cnt_d        = 2'd0;
                  len_d        = '0;
               end else begin
                  state_d = DATA;
                  proc_c  = 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase

         // Two newest bytes stay in the delay line; only the evicted one is payload
         if (proc_c) begin
            fcs_d  = fcs_next_c;
            dly0_d = dly1_q;
            dly1_d = byte_c;
            if (cnt_q == 2'd2) begin
               if (len_q == LEN_MAX) begin
                  frame_done_d = 1'b1;
                  frame_good_d = 1'b0;
                  frame_len_d  = LEN_MAX;
                  state_d      = HUNT;
                  fcs_d        = FCS_INIT;
                  cnt_d        = 2'd0;
                  len_d        = '0;
               end else begin
                  out_strobe_d = 1'b1;
                  out_data_d   = dly0_q;
                  len_d        = len_q + LEN_BITS'(1);
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HUNT;
         fcs_q        <= FCS_INIT;
         dly0_q       <= 8'h00;
         dly1_q       <= 8'h00;
         cnt_q        <= 2'd0;
         len_q        <= '0;
         out_data_q   <= 8'h00;
         out_strobe_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_good_q <= 1'b0;
         frame_len_q  <= '0;
      end else begin
         state_q      <= state_d;
         fcs_q        <= fcs_d;
         dly0_q       <= dly0_d;
         dly1_q       <= dly1_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         out_data_q   <= out_data_d;
         out_strobe_q <= out_strobe_d;
         frame_done_q <= frame_done_d;
         frame_good_q <= frame_good_d;
         frame_len_q  <= frame_len_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_strobe = out_strobe_q;
   assign frame_done = frame_done_q;
   assign frame_good = frame_good_q;
   assign frame_len  = frame_len_q;

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Decoder end of the team's RFC1662-inspired serial packet framing.
- Consumes the raw byte stream from uart_rx (data + data_strobe), finds frames delimited by flag bytes, removes byte stuffing, strips and checks the 16-bit FCS, and emits payload bytes with a per-frame status pulse.
- Sits between uart_rx, or a uart_rx_fifo drain, and the packet command logic.

Parameters:
- MAX_LEN, 256: maximum payload bytes per frame, FCS excluded. Longer frames are aborted.
- LEN_BITS, CLOG2(MAX_LEN+1): width of frame_len.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  raw received byte, valid only while in_strobe is high.
- in_strobe  input  1  single-cycle pulse per received byte.
- out_data  output  8  unstuffed payload byte.
- out_strobe  output  1  single-cycle pulse per payload byte.
- frame_done  output  1  single-cycle pulse when a frame ends, either by closing flag or by abort.
- frame_good  output  1  valid with frame_done: FCS correct and no abort.
- frame_len  output  LEN_BITS  payload byte count, valid with frame_done.

Behaviour:
- Reset (asynchronous, active-high) values:
  - All outputs are 0.
  - State is HUNT.
  - Delay line is empty (count 0).
  - FCS register is 0xFFFF.
  - Length is 0.
- Constants: FLAG=0x7E, ESC=0x7D, XOR mask 0x20.
- FCS is CRC-16/PPP:
  - Reflected polynomial 0x8408, init 0xFFFF.
  - Updated on every unstuffed byte, FCS bytes included.
  - Frame is good iff the register equals residue 0xF0B8 at the closing flag.
- Only cycles with in_strobe high advance the FSM. Inputs are ignored otherwise.
- States and transitions:
  - HUNT: discard bytes until FLAG, then go to IDLE.
  - IDLE: FLAG stays in IDLE (back-to-back flags are an empty frame, no frame_done). ESC goes to ESC_S. Any other byte goes to DATA; the byte is processed.
  - DATA: FLAG closes the frame, then go to IDLE. ESC goes to ESC_S. Any other byte is processed.
  - ESC_S: FLAG is an abort (frame_done=1, frame_good=0), then go to IDLE. Any other byte is XORed with 0x20, processed, then go to DATA.
- Processing a byte:
  - Update FCS.
  - Push the byte into a 2-entry delay line, so the last two bytes are held back as FCS.
  - If the delay line was already full, the evicted oldest byte is driven on out_data with out_strobe=1 in the next cycle, and length increments.
- Latency: out_strobe occurs exactly 1 clk after the in_strobe that evicts the byte.
- Closing flag:
  - Delay line count < 2 (runt): frame_done=1, frame_good=0.
  - Otherwise: frame_done=1, frame_good=(fcs==0xF0B8).
  - Either way frame_len = emitted count. The pulse is 1 clk after the flag strobe.
  - Then reset FCS, delay line and length, and go to IDLE. The flag also serves as the opening flag of the next frame.
- Overlength: when an eviction would make length exceed MAX_LEN:
  - Suppress that byte.
  - Pulse frame_done=1, frame_good=0, frame_len=MAX_LEN.
  - Go to HUNT.
- out_strobe and frame_done never assert in the same cycle.
- A pending frame_done takes priority over nothing, because evictions and flags come from distinct input bytes.
- Reset mid-frame: everything clears immediately, returns to HUNT, and no frame_done is emitted.
- Consumers must discard emitted payload when frame_good=0. The block has no payload rollback and no backpressure; out_strobe rate ≤ in_strobe rate.

Decomposition:
- Package uart_frame_pkg holds:
  - FLAG, ESC and ESC_XOR.
  - FCS_INIT=0xFFFF and FCS_GOOD=0xF0B8.
  - The state enum {HUNT, IDLE, DATA, ESC_S}.
- Sub-module crc16_ppp_byte: combinational next-FCS from (fcs, byte). It will be reused by the future transmit framer.

Test Plan:
- Good frame: stream 7E 31 32 33 34 35 36 37 38 39 6E 90 7E, strobes 4 clk apart.
  - Expect out_data 0x31..0x39 (9 strobes), each 1 clk after the corresponding eviction.
  - Expect frame_done=1, frame_good=1, frame_len=9 one clk after the last 7E.
- Stuffing: after reset, send 7E then a frame containing 7D 5E and 7D 5D with a correct FCS.
  - Expect payload bytes 0x7E and 0x7D out, frame_good=1.
- Bad FCS: same as the good frame but with FCS 6E 91.
  - Expect 9 bytes out, then frame_done=1, frame_good=0, frame_len=9.
- Abort and runt:
  - 7E 41 7D 7E: frame_done with frame_good=0, frame_len=0, no out_strobe.
  - 7E 7E 7E: no frame_done.
  - 7E 41 7E: runt, frame_done with frame_good=0.
- Hunt and overlength:
  - Bytes 55 AA before the first 7E produce no output.
  - With MAX_LEN=4, a 6-byte payload frame gives exactly 4 out_strobes and frame_done with frame_good=0, frame_len=4.
  - The trailing bytes are ignored until the next 7E.
- Async reset asserted mid-frame between clk edges: outputs go to 0 immediately, and the following good frame decodes correctly only after a fresh 7E.
